// File: rtl/bf_pkg.sv
// bf_pkg: shared constants, command encodings, frame field positions and FSM states
package bf_pkg;
  localparam int NUM_CH = 8;
  localparam int W_WIDTH = 5;
  localparam int FRAME_BITS = 32;
  localparam int CMD_LSB = 30;
  localparam int CH_LSB = 27;
  localparam int COS1_LSB = 15;
  localparam int SIN1_LSB = 10;
  localparam int COS2_LSB = 5;
  localparam int SIN2_LSB = 0;
  typedef enum logic [1:0] {CMD_NOP = 2'b00, CMD_WRITE = 2'b01, CMD_COMMIT = 2'b10, CMD_CLEAR = 2'b11} cmd_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;
endpackage

// File: rtl/bf_spi_rx.sv
// bf_spi_rx: synchronizes the SPI pins, frames on SS_N and shifts in one command word
module bf_spi_rx
  import bf_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        frame_valid,
  output logic [31:0] word,
  output logic [5:0]  bit_cnt
);
  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
  logic sclk_d;
  logic sclk_rise;
  state_t state;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  // IDLE leaves on the select level, so a frame reselected during DECODE is still caught
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      ss_q <= '1;
      sclk_d <= 1'b0;
      state <= IDLE;
      frame_valid <= 1'b0;
      word <= '0;
      bit_cnt <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      ss_q <= {ss_q[SYNC_STAGES-2:0], ss_n};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      frame_valid <= 1'b0;
      case (state)
        IDLE:
          if (!ss_q[SYNC_STAGES-1]) begin
            state <= SHIFT;
            word <= '0;
            bit_cnt <= '0;
          end
        SHIFT:
          if (ss_q[SYNC_STAGES-1]) begin
            state <= DECODE;
            frame_valid <= 1'b1;
          end else if (sclk_rise) begin
            word <= {word[30:0], mosi_q[SYNC_STAGES-1]};
            bit_cnt <= (bit_cnt == 6'd33) ? bit_cnt : bit_cnt + 6'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/bf_weight_ctrl.sv
// bf_weight_ctrl: SPI-loaded shadow beamformer weights, committed to the active bank on a frame tick
module bf_weight_ctrl
  import bf_pkg::*;
#(
  parameter int NUM_CH = bf_pkg::NUM_CH,
  parameter int W_WIDTH = bf_pkg::W_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sclk,
  input  logic                        mosi,
  input  logic                        ss_n,
  input  logic                        frame_tick,
  output logic [NUM_CH*W_WIDTH-1:0]   w_cos_1,
  output logic [NUM_CH*W_WIDTH-1:0]   w_sin_1,
  output logic [NUM_CH*W_WIDTH-1:0]   w_cos_2,
  output logic [NUM_CH*W_WIDTH-1:0]   w_sin_2,
  output logic                        commit_pending,
  output logic                        commit_done,
  output logic                        frame_err,
  output logic [7:0]                  err_cnt
);
  logic frame_valid;
  logic [31:0] word;
  logic [5:0] bit_cnt;
  logic [NUM_CH*W_WIDTH-1:0] s_cos_1, s_sin_1, s_cos_2, s_sin_2;
  cmd_t cmd;
  logic [2:0] ch;
  logic ok, acc, commit;
  bf_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clock(clock),
    .reset(reset),
    .sclk(sclk),
    .mosi(mosi),
    .ss_n(ss_n),
    .frame_valid(frame_valid),
    .word(word),
    .bit_cnt(bit_cnt)
  );
  assign cmd = cmd_t'(word[CMD_LSB +: 2]);
  assign ch = word[CH_LSB +: 3];
  assign ok = bit_cnt == 6'd32 && !(commit_pending && (cmd == CMD_WRITE || cmd == CMD_CLEAR));
  assign acc = frame_valid && ok;
  assign commit = commit_pending && frame_tick;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      w_cos_1 <= '0;
      w_sin_1 <= '0;
      w_cos_2 <= '0;
      w_sin_2 <= '0;
      s_cos_1 <= '0;
      s_sin_1 <= '0;
      s_cos_2 <= '0;
      s_sin_2 <= '0;
      commit_pending <= 1'b0;
      commit_done <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      commit_done <= commit;
      frame_err <= frame_valid && !ok;
      if (frame_valid && !ok && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      // pending only counts once registered, so a tick in the setting cycle cannot commit
      if (commit) begin
        w_cos_1 <= s_cos_1;
        w_sin_1 <= s_sin_1;
        w_cos_2 <= s_cos_2;
        w_sin_2 <= s_sin_2;
        commit_pending <= 1'b0;
      end else if (acc && (cmd == CMD_COMMIT || cmd == CMD_CLEAR)) commit_pending <= 1'b1;
      if (acc && cmd == CMD_WRITE && int'(ch) < NUM_CH) begin
        s_cos_1[int'(ch)*W_WIDTH +: W_WIDTH] <= word[COS1_LSB +: W_WIDTH];
        s_sin_1[int'(ch)*W_WIDTH +: W_WIDTH] <= word[SIN1_LSB +: W_WIDTH];
        s_cos_2[int'(ch)*W_WIDTH +: W_WIDTH] <= word[COS2_LSB +: W_WIDTH];
        s_sin_2[int'(ch)*W_WIDTH +: W_WIDTH] <= word[SIN2_LSB +: W_WIDTH];
      end
      if (acc && cmd == CMD_CLEAR) begin
        s_cos_1 <= '0;
        s_sin_1 <= '0;
        s_cos_2 <= '0;
        s_sin_2 <= '0;
      end
    end
endmodule

// File: tb/tb_bf_weight_ctrl.sv
// tb_bf_weight_ctrl: scenario tasks with a commit scoreboard for bf_weight_ctrl
module tb_bf_weight_ctrl;
  typedef struct packed {
    logic [39:0] c1;
    logic [39:0] s1;
    logic [39:0] c2;
    logic [39:0] s2;
  } bank_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic ss_n = 1'b1;
  logic frame_tick = 1'b0;
  logic [39:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic commit_pending, commit_done, frame_err;
  logic [7:0] err_cnt;
  bank_t sh;
  bank_t e;
  bank_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int done_seen = 0;
  bf_weight_ctrl dut (
    .clock(clock),
    .reset(reset),
    .sclk(sclk),
    .mosi(mosi),
    .ss_n(ss_n),
    .frame_tick(frame_tick),
    .w_cos_1(w_cos_1),
    .w_sin_1(w_sin_1),
    .w_cos_2(w_cos_2),
    .w_sin_2(w_sin_2),
    .commit_pending(commit_pending),
    .commit_done(commit_done),
    .frame_err(frame_err),
    .err_cnt(err_cnt)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (frame_err) err_seen++;
    if (commit_done) begin
      done_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: active c1=%h s1=%h c2=%h s2=%h, required no commit", w_cos_1, w_sin_1, w_cos_2, w_sin_2);
      end else begin
        e = exp_q.pop_front();
        if ({w_cos_1, w_sin_1, w_cos_2, w_sin_2} !== e) begin
          errors++;
          $display("FAIL commit_bank: got c1=%h s1=%h c2=%h s2=%h, required c1=%h s1=%h c2=%h s2=%h", w_cos_1, w_sin_1, w_cos_2, w_sin_2, e.c1, e.s1, e.c2, e.s2);
        end
      end
    end
  end
  function automatic logic [31:0] mk(input logic [1:0] cmd, input logic [2:0] ch, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    return {cmd, ch, 7'b0, a, b, c, d};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic apply_reset;
    reset = 1'b0;
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    frame_tick = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    sh = '0;
    exp_q.delete();
  endtask
  task automatic set_sh(input int ch, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    sh.c1[ch*5 +: 5] = a;
    sh.s1[ch*5 +: 5] = b;
    sh.c2[ch*5 +: 5] = c;
    sh.s2[ch*5 +: 5] = d;
  endtask
  task automatic spi_send(input logic [31:0] w, input int n, input int gap);
    ss_n = 1'b0;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      mosi = (i < 32) ? w[31-i] : 1'b0;
      cyc(4);
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
    cyc(4);
    ss_n = 1'b1;
    cyc(gap);
  endtask
  task automatic tick;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(2);
  endtask
  task automatic test_reset;
    reset = 1'b0;
    cyc(2);
    checks++;
    if ({w_cos_1, w_sin_1, w_cos_2, w_sin_2} !== 160'b0) begin
      errors++;
      $display("FAIL reset_active: got %h, required 0", {w_cos_1, w_sin_1, w_cos_2, w_sin_2});
    end
    checks++;
    if ({commit_pending, commit_done, frame_err, err_cnt} !== 11'b0) begin
      errors++;
      $display("FAIL reset_status: got pend=%b done=%b err=%b cnt=%0d, required all 0", commit_pending, commit_done, frame_err, err_cnt);
    end
    apply_reset;
  endtask
  task automatic test_write_commit;
    int e0, d0;
    apply_reset;
    e0 = err_seen;
    d0 = done_seen;
    spi_send(mk(2'b01, 3'd3, 5'd9, 5'h14, 5'd0, 5'h11), 32, 8);
    set_sh(3, 5'd9, 5'h14, 5'd0, 5'h11);
    checks++;
    if (commit_pending !== 1'b0 || err_seen != e0) begin
      errors++;
      $display("FAIL write_accept: got pend=%b errs=%0d, required pend=0 errs=%0d", commit_pending, err_seen, e0);
    end
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 8);
    checks++;
    if (commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_pending_set: got %b, required 1", commit_pending);
    end
    exp_q.push_back(sh);
    tick;
    cyc(3);
    checks++;
    if (done_seen != d0 + 1 || commit_done !== 1'b0 || commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL commit_done_pulse: got pulses=%0d done=%b pend=%b, required pulses=%0d done=0 pend=0", done_seen - d0, commit_done, commit_pending, 1);
    end
    checks++;
    if (w_cos_1 !== 40'h48000 || w_sin_1 !== 40'hA0000 || w_cos_2 !== 40'h0 || w_sin_2 !== 40'h88000) begin
      errors++;
      $display("FAIL ch3_weights: got c1=%h s1=%h c2=%h s2=%h, required c1=48000 s1=a0000 c2=0 s2=88000", w_cos_1, w_sin_1, w_cos_2, w_sin_2);
    end
  endtask
  task automatic test_no_commit;
    int d0;
    apply_reset;
    d0 = done_seen;
    spi_send(mk(2'b01, 3'd0, 5'd1, 5'd2, 5'd3, 5'd4), 32, 8);
    repeat (5) tick;
    checks++;
    if ({w_cos_1, w_sin_1, w_cos_2, w_sin_2} !== 160'b0 || commit_pending !== 1'b0 || done_seen != d0) begin
      errors++;
      $display("FAIL no_commit: got active=%h pend=%b pulses=%0d, required active=0 pend=0 pulses=0", {w_cos_1, w_sin_1, w_cos_2, w_sin_2}, commit_pending, done_seen - d0);
    end
  endtask
  task automatic test_bad_len;
    int e0, d0;
    apply_reset;
    spi_send(mk(2'b01, 3'd1, 5'd5, 5'd6, 5'd7, 5'd8), 32, 8);
    set_sh(1, 5'd5, 5'd6, 5'd7, 5'd8);
    e0 = err_seen;
    d0 = done_seen;
    spi_send(mk(2'b01, 3'd1, 5'h1f, 5'h1f, 5'h1f, 5'h1f), 31, 8);
    spi_send(mk(2'b01, 3'd1, 5'h0a, 5'h0b, 5'h0c, 5'h0d), 33, 8);
    checks++;
    if (err_seen != e0 + 2 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL bad_len_err: got pulses=%0d cnt=%0d, required pulses=2 cnt=2", err_seen - e0, err_cnt);
    end
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 8);
    exp_q.push_back(sh);
    tick;
    checks++;
    if (done_seen != d0 + 1) begin
      errors++;
      $display("FAIL bad_len_commit: got pulses=%0d, required 1", done_seen - d0);
    end
  endtask
  task automatic test_pending_reject;
    int e0, d0;
    apply_reset;
    spi_send(mk(2'b01, 3'd2, 5'd3, 5'h1d, 5'd7, 5'h10), 32, 8);
    set_sh(2, 5'd3, 5'h1d, 5'd7, 5'h10);
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 8);
    e0 = err_seen;
    d0 = done_seen;
    spi_send(mk(2'b01, 3'd2, 5'd11, 5'd12, 5'd13, 5'd14), 32, 8);
    checks++;
    if (err_seen != e0 + 1 || err_cnt !== 8'd1 || commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_reject: got pulses=%0d cnt=%0d pend=%b, required pulses=1 cnt=1 pend=1", err_seen - e0, err_cnt, commit_pending);
    end
    exp_q.push_back(sh);
    tick;
    checks++;
    if (done_seen != d0 + 1) begin
      errors++;
      $display("FAIL pending_reject_commit: got pulses=%0d, required 1", done_seen - d0);
    end
  endtask
  task automatic test_tick_coincide;
    int d0;
    apply_reset;
    spi_send(mk(2'b01, 3'd4, 5'd15, 5'h10, 5'd1, 5'h1f), 32, 8);
    set_sh(4, 5'd15, 5'h10, 5'd1, 5'h1f);
    d0 = done_seen;
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 0);
    cyc(3);
    checks++;
    if (commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL coincide_pre: got pend=%b, required 0", commit_pending);
    end
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    checks++;
    if (commit_pending !== 1'b1 || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL coincide_set: got pend=%b done=%b, required pend=1 done=0", commit_pending, commit_done);
    end
    cyc(5);
    checks++;
    if (done_seen != d0 || {w_cos_1, w_sin_1, w_cos_2, w_sin_2} !== 160'b0) begin
      errors++;
      $display("FAIL coincide_hold: got pulses=%0d active=%h, required pulses=0 active=0", done_seen - d0, {w_cos_1, w_sin_1, w_cos_2, w_sin_2});
    end
    exp_q.push_back(sh);
    tick;
    checks++;
    if (done_seen != d0 + 1 || commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL coincide_next: got pulses=%0d pend=%b, required pulses=1 pend=0", done_seen - d0, commit_pending);
    end
  endtask
  task automatic test_back_to_back;
    int e0;
    apply_reset;
    e0 = err_seen;
    spi_send(mk(2'b01, 3'd5, 5'd2, 5'd4, 5'd6, 5'd8), 32, 2);
    set_sh(5, 5'd2, 5'd4, 5'd6, 5'd8);
    spi_send(mk(2'b01, 3'd7, 5'h11, 5'h13, 5'h15, 5'h17), 32, 8);
    set_sh(7, 5'h11, 5'h13, 5'h15, 5'h17);
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 2);
    exp_q.push_back(sh);
    cyc(8);
    tick;
    checks++;
    if (err_seen != e0 || w_cos_1 !== sh.c1 || w_sin_2 !== sh.s2) begin
      errors++;
      $display("FAIL back_to_back: got errs=%0d c1=%h s2=%h, required errs=0 c1=%h s2=%h", err_seen - e0, w_cos_1, w_sin_2, sh.c1, sh.s2);
    end
  endtask
  task automatic test_clear;
    apply_reset;
    spi_send(mk(2'b01, 3'd6, 5'd7, 5'd7, 5'd7, 5'd7), 32, 8);
    set_sh(6, 5'd7, 5'd7, 5'd7, 5'd7);
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 8);
    exp_q.push_back(sh);
    tick;
    spi_send(mk(2'b11, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 8);
    sh = '0;
    checks++;
    if (commit_pending !== 1'b1 || w_cos_1 !== 40'h7_0000_0000 >> 2) begin
      errors++;
      $display("FAIL clear_pending: got pend=%b c1=%h, required pend=1 c1=%h", commit_pending, w_cos_1, 40'h7_0000_0000 >> 2);
    end
    exp_q.push_back(sh);
    tick;
    checks++;
    if ({w_cos_1, w_sin_1, w_cos_2, w_sin_2} !== 160'b0) begin
      errors++;
      $display("FAIL clear_active: got %h, required 0", {w_cos_1, w_sin_1, w_cos_2, w_sin_2});
    end
  endtask
  task automatic test_mid_reset;
    logic [31:0] w;
    int e0, d0;
    apply_reset;
    e0 = err_seen;
    d0 = done_seen;
    w = mk(2'b01, 3'd6, 5'h1f, 5'h1e, 5'h1d, 5'h1c);
    ss_n = 1'b0;
    cyc(4);
    for (int i = 0; i < 16; i++) begin
      mosi = w[31-i];
      cyc(4);
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
    reset = 1'b0;
    cyc(1);
    ss_n = 1'b1;
    mosi = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(6);
    checks++;
    if (err_seen != e0 || err_cnt !== 8'd0 || commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_discard: got pulses=%0d cnt=%0d pend=%b, required 0 0 0", err_seen - e0, err_cnt, commit_pending);
    end
    spi_send(mk(2'b01, 3'd6, 5'd1, 5'd3, 5'd5, 5'h19), 32, 8);
    set_sh(6, 5'd1, 5'd3, 5'd5, 5'h19);
    spi_send(mk(2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0), 32, 8);
    exp_q.push_back(sh);
    tick;
    checks++;
    if (err_seen != e0 || done_seen != d0 + 1) begin
      errors++;
      $display("FAIL mid_reset_frame: got errs=%0d pulses=%0d, required errs=0 pulses=1", err_seen - e0, done_seen - d0);
    end
  endtask
  task automatic test_err_sat;
    int e0;
    apply_reset;
    e0 = err_seen;
    for (int i = 0; i < 260; i++) spi_send(32'h0, 0, 6);
    checks++;
    if (err_cnt !== 8'd255 || err_seen != e0 + 260) begin
      errors++;
      $display("FAIL err_saturate: got cnt=%0d pulses=%0d, required cnt=255 pulses=260", err_cnt, err_seen - e0);
    end
  endtask
  initial begin
    test_reset;
    test_write_commit;
    test_no_commit;
    test_bad_len;
    test_pending_reject;
    test_tick_coincide;
    test_back_to_back;
    test_clear;
    test_mid_reset;
    test_err_sat;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding commits, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bf_weight_ctrl.md
BF_WEIGHT_CTRL -- requirements
Module: bf_weight_ctrl

Interface
REQ-001 Parameter NUM_CH, 8, number of beamformer channels.
REQ-002 Parameter W_WIDTH, 5, signed two's-complement weight width.
REQ-003 Parameter SYNC_STAGES, 2, synchronizer depth on SCLK/MOSI/SS_N.
REQ-004 CLOCK  in  1  system clock; the only clock in the block.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 SCLK  in  1  SPI clock, asynchronous to CLOCK, at most CLOCK/8.
REQ-007 MOSI  in  1  SPI data, MSB first, valid on SCLK rising edge.
REQ-008 SS_N  in  1  SPI select, active-low, frames one 32-bit command.
REQ-009 FRAME_TICK  in  1  one-cycle pulse marking a delta-sigma sample boundary.
REQ-010 W_COS_1, W_SIN_1, W_COS_2, W_SIN_2  out  NUM_CH*W_WIDTH each  active weights; channel k occupies bits [k*W_WIDTH +: W_WIDTH].
REQ-011 COMMIT_PENDING  out  1  shadow bank awaiting transfer to active.
REQ-012 COMMIT_DONE  out  1  one-cycle pulse when active bank updated.
REQ-013 FRAME_ERR  out  1  one-cycle pulse on a rejected frame.
REQ-014 ERR_CNT  out  8  count of rejected frames, saturating.

Function
REQ-015 SCLK, MOSI and SS_N SHALL pass through SYNC_STAGES flops; SCLK rising edge detected on synchronized copy.
REQ-016 FSM states SHALL be IDLE, SHIFT, DECODE; IDLE->SHIFT on synced SS_N falling; SHIFT->DECODE on synced SS_N rising; DECODE->IDLE after one cycle.
REQ-017 In SHIFT each detected SCLK rise SHALL shift MOSI into a 32-bit register and increment a 6-bit bit counter saturating at 33.
REQ-018 Frame layout SHALL be [31:30] cmd, [29:27] channel, [26:20] reserved (ignored), [19:15] cos1, [14:10] sin1, [9:5] cos2, [4:0] sin2.
REQ-019 cmd 00 = NOP; 01 = WRITE channel shadow weights; 10 = COMMIT; 11 = CLEAR (all shadow weights to 0 and set pending).
REQ-020 In DECODE, bit count not equal to 32 SHALL reject the frame: no state change, FRAME_ERR pulse.
REQ-021 WRITE or CLEAR received while COMMIT_PENDING=1 SHALL be rejected as in REQ-020.
REQ-022 COMMIT SHALL set COMMIT_PENDING the cycle after DECODE; COMMIT while already pending is a NOP, not an error.
REQ-023 With COMMIT_PENDING=1, the first FRAME_TICK cycle SHALL copy all shadow weights to active (visible next cycle), clear COMMIT_PENDING, and pulse COMMIT_DONE.
REQ-024 FRAME_TICK in the same cycle that COMMIT_PENDING is being set SHALL NOT commit; commit occurs on the following FRAME_TICK.
REQ-025 Active weights SHALL change only per REQ-023; all four outputs of all channels update in the same cycle.
REQ-026 ERR_CNT SHALL increment by one per FRAME_ERR and hold at 255.
REQ-027 SS_N deassert then reassert before DECODE completes SHALL not be lost: the new frame enters SHIFT from IDLE on its synced falling edge.

Reset
REQ-028 On RESET low: FSM IDLE, shift register and bit counter 0, shadow and active weights 0, COMMIT_PENDING 0, COMMIT_DONE 0, FRAME_ERR 0, ERR_CNT 0, synchronizers to idle level (SCLK 0, SS_N 1).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without FRAME_ERR; RESET deassertion is synchronized to CLOCK by the integrator.

Structure
REQ-030 Shared package bf_pkg SHALL hold NUM_CH, W_WIDTH, cmd encodings, frame field positions, and FSM state enum.
REQ-031 One sub-module, bf_spi_rx (synchronizer, edge detect, shift register, bit counter), SHALL feed a frame-valid pulse, 32-bit word and bit count to the decode/bank logic.

Verification
REQ-032 WRITE ch3 cos1=9 sin1=-12 cos2=0 sin2=-15, COMMIT, FRAME_TICK -> W_COS_1[19:15]=01001, W_SIN_1[19:15]=10100, W_SIN_2[19:15]=10001, COMMIT_DONE one cycle, others 0.
REQ-033 WRITE ch0 without COMMIT, 5 FRAME_TICKs -> active weights stay 0, COMMIT_PENDING 0.
REQ-034 31-bit frame, then 33-bit frame -> two FRAME_ERR pulses, ERR_CNT=2, shadow unchanged.
REQ-035 COMMIT then WRITE before FRAME_TICK -> WRITE rejected, ERR_CNT=1; after tick, active equals pre-WRITE shadow.
REQ-036 COMMIT whose pending-set cycle coincides with FRAME_TICK -> no update that tick; update and COMMIT_DONE on next FRAME_TICK.
REQ-037 RESET low mid-frame after 16 bits, then full WRITE frame -> no FRAME_ERR, second frame accepted normally.
